// File: rtl/tick_tx_pkg.sv
// rtl/tick_tx_pkg.sv - shared types and constants for the tick-paced serial transmitter
package tick_tx_pkg;

  // Frame phases, in transmission order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Plain constants carrying the same encodings as tx_state_t, so older blocks
  // that keep their state in a bare logic vector can share the encoding.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Level the line rests at between frames; also the stop-bit level.
  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tick_serial_tx_if.sv
// rtl/tick_serial_tx_if.sv - parallel word handshake into the serial transmitter
interface tick_serial_tx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  // Producer side: offers words, watches ready.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  // Transmitter side: takes a word when valid and ready are both high.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/tick_bit_timer.sv
// rtl/tick_bit_timer.sv - counts tick pulses and flags the last tick of each bit
module tick_bit_timer #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic bit_end
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The bit ends on the tick that would take the count past its terminal value.
  assign bit_end = tick && (cnt_q == CNT_LAST);

  // Clear dominates; otherwise advance only on tick, wrapping at the bit end.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end
  end

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_serial_tx.sv
// rtl/tick_serial_tx.sv - tick-paced serial frame transmitter: start, data LSB first, parity, stop
module tick_serial_tx
  import tick_tx_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int TICKS_PER_BIT = 4,
  parameter int PARITY_EN     = 1,
  parameter int STOP_BITS     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  tick_serial_tx_if.slave   in_if,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int            BW        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  // Reject parameter sets the frame format cannot express.
  generate
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("tick_serial_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_W < 1) begin : g_bad_data_w
      $error("tick_serial_tx: DATA_W must be at least 1");
    end
    if (TICKS_PER_BIT < 1) begin : g_bad_ticks
      $error("tick_serial_tx: TICKS_PER_BIT must be at least 1");
    end
  endgenerate

  logic [2:0]        state_q,    state_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic              parity_q,   parity_d;
  logic [BW-1:0]     bit_idx_q,  bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic              tx_q,       tx_d;
  logic              done_q,     done_d;
  logic              busy_q;

  logic              in_ready;
  logic              accept;
  logic              bit_end;
  logic [DATA_W-1:0] shifted;

  assign in_ready       = (state_q == ST_IDLE);
  assign in_if.in_ready = in_ready;
  assign accept         = in_if.in_valid && in_ready;
  assign shifted        = shift_q >> 1;

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

  // Holding the timer clear while idle means ticks are ignored there, and every
  // frame starts its first bit from a zero count.
  tick_bit_timer #(
    .N (TICKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (in_ready),
    .tick    (tick),
    .bit_end (bit_end)
  );

  // Frame sequencing: each phase advances only when the timer reports a bit end,
  // and tx_d is the level of the bit being entered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = TX_IDLE_LEVEL;
        if (accept) begin
          shift_d    = in_if.in_data;
          parity_d   = ^in_if.in_data;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
          tx_d       = 1'b0;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          shift_d = shifted;
          if (bit_idx_q == BIT_LAST) begin
            // Index stays at its terminal value; it is reloaded on the next accept.
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = TX_IDLE_LEVEL;
            end
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
            tx_d      = shifted[0];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = TX_IDLE_LEVEL;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == STOP_LAST) begin
            state_d = ST_IDLE;
            tx_d    = TX_IDLE_LEVEL;
            done_d  = 1'b1;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = TX_IDLE_LEVEL;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= TX_IDLE_LEVEL;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_tick_serial_tx.sv
// tb/tb_tick_serial_tx.sv - self-checking bench for tick_serial_tx against a bit-level frame model
module tb_tick_serial_tx;

  localparam int DATA_W = 8;
  localparam int TPB    = 4;
  localparam int PEN    = 1;
  localparam int SB     = 1;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic tx;
  logic busy;
  logic done;

  bit   tick_en = 1'b0;
  int   phase;

  int   checks = 0;
  int   errors = 0;

  logic obs[$];
  logic expq[$];
  int   done_cnt = 0;

  tick_serial_tx_if #(.DATA_W(DATA_W)) in_if ();

  tick_serial_tx #(
    .DATA_W        (DATA_W),
    .TICKS_PER_BIT (TPB),
    .PARITY_EN     (PEN),
    .STOP_BITS     (SB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .in_if (in_if),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Tick on every third cycle while enabled, changed well away from the clock edge.
  initial begin
    phase = 0;
    tick  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick  = tick_en && (phase == 0);
      phase = (phase == 2) ? 0 : phase + 1;
    end
  end

  // Record the line level at every tick that falls inside a frame, and count done pulses.
  always @(negedge clk) begin
    if (!rst && tick && busy) obs.push_back(tx);
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for each tick of a frame: start, data LSB first, parity, stops.
  task automatic model_frame(input logic [DATA_W-1:0] w);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bits.push_back(w[i]);
    if (PEN != 0) bits.push_back(^w);
    for (int i = 0; i < SB; i++) bits.push_back(1'b1);
    foreach (bits[i]) for (int t = 0; t < TPB; t++) expq.push_back(bits[i]);
  endtask

  task automatic check_obs(input string tag, input int base);
    int bad = 0;
    check({tag, "_ticks"}, obs.size() - base, expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (base + i >= obs.size() || obs[base + i] !== expq[i]) bad++;
    check({tag, "_bits"}, bad, 0);
    expq.delete();
  endtask

  task automatic send(input logic [DATA_W-1:0] w);
    int n = 0;
    while (!in_if.in_ready && n < 400) begin step(); n++; end
    if (n >= 400) check("send_ready_timeout", 0, 1);
    in_if.in_data  = w;
    in_if.in_valid = 1'b1;
    step();
    in_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin step(); n++; end
    if (n >= 400) check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_obs(input int target);
    int n = 0;
    while (obs.size() < target && n < 400) begin step(); n++; end
    if (n >= 400) check("obs_timeout", obs.size(), target);
  endtask

  initial begin
    int base;
    int d0;
    int changes;
    int rdy_seen;
    int snap_n;
    logic snap_tx;
    logic snap_busy;
    logic [DATA_W-1:0] w;

    rst            = 1'b1;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    tick_en        = 1'b1;

    // Reset held for two cycles, then idle.
    step(); step();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", in_if.in_ready, 1);
    rst = 1'b0;
    repeat (5) step();
    check("idle_tx", tx, 1);
    check("idle_ready", in_if.in_ready, 1);

    // Single frame 0xA5.
    d0 = done_cnt; base = obs.size();
    send(8'hA5);
    check("a5_tx_start", tx, 0);
    check("a5_busy", busy, 1);
    wait_done("a5");
    check("a5_done_ready", in_if.in_ready, 1);
    step(); step();
    check("a5_done_cnt", done_cnt - d0, 1);
    check("a5_tx_after", tx, 1);
    model_frame(8'hA5);
    check_obs("a5", base);

    // Back-to-back 0x01 then 0xFF with valid held across the done cycle.
    repeat (4) step();
    d0 = done_cnt; base = obs.size();
    in_if.in_data  = 8'h01;
    in_if.in_valid = 1'b1;
    step();
    in_if.in_data  = 8'hFF;
    wait_done("b2b_first");
    step();
    check("b2b_gap_tx", tx, 0);
    check("b2b_gap_busy", busy, 1);
    in_if.in_valid = 1'b0;
    wait_done("b2b_second");
    step(); step();
    check("b2b_done_cnt", done_cnt - d0, 2);
    model_frame(8'h01);
    model_frame(8'hFF);
    check_obs("b2b", base);

    // Tick withheld for 50 cycles in the middle of data bit 2.
    repeat (3) step();
    base = obs.size();
    send(8'h96);
    wait_obs(base + 4 * 3 + 2);
    tick_en = 1'b0;
    step();
    snap_tx = tx; snap_busy = busy; snap_n = obs.size();
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx !== snap_tx || busy !== snap_busy) changes++;
    end
    check("freeze_changes", changes, 0);
    check("freeze_ticks", obs.size(), snap_n);
    check("freeze_busy", busy, 1);
    tick_en = 1'b1;
    wait_done("freeze");
    step(); step();
    model_frame(8'h96);
    check_obs("freeze", base);

    // Reset during data bit 3 aborts the frame with no done.
    repeat (3) step();
    base = obs.size();
    send(8'hC3);
    wait_obs(base + 4 * 4 + 1);
    d0 = done_cnt;
    rst = 1'b1;
    step();
    check("abort_tx", tx, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", in_if.in_ready, 1);
    rst = 1'b0;
    repeat (200) step();
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle_tx", tx, 1);

    // A word offered while busy is ignored.
    d0 = done_cnt; base = obs.size();
    send(8'h55);
    repeat (5) step();
    in_if.in_data  = 8'h3C;
    in_if.in_valid = 1'b1;
    rdy_seen = 0;
    for (int n = 0; n < 400 && obs.size() < base + 40; n++) begin
      step();
      if (in_if.in_ready !== 1'b0) rdy_seen++;
    end
    check("busy_ready_low", rdy_seen, 0);
    in_if.in_valid = 1'b0;
    wait_done("ignore");
    step(); step();
    check("ignore_done_cnt", done_cnt - d0, 1);
    check("ignore_idle_busy", busy, 0);
    model_frame(8'h55);
    check_obs("ignore", base);

    // Random words with random idle gaps.
    for (int k = 0; k < 6; k++) begin
      w = DATA_W'($urandom);
      repeat ($urandom_range(0, 20)) step();
      d0 = done_cnt; base = obs.size();
      send(w);
      wait_done("rand");
      step(); step();
      check("rand_done_cnt", done_cnt - d0, 1);
      model_frame(w);
      check_obs("rand", base);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
